heat_solver_sequencer: RTL and testbench

//  Sequences the heat-map solver array for one HPS-issued run of N diffusion iterations.
//  Per iteration: issues row-step requests 0..NUM_ROWS-1 to the column solvers via valid/ready,

---
 rtl/heat_seq_pkg.sv | 16 +
 rtl/heat_solver_sequencer_if.sv | 14 +
 rtl/heat_seq_row_counter.sv | 24 ++
 rtl/heat_solver_sequencer.sv | 129 ++++++++++++
 tb/tb_heat_solver_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/heat_seq_pkg.sv
// Shared types and default sizing for the heat-map solver sequencer.
package heat_seq_pkg;

  localparam int NUM_ROWS_DEF = 480;
  localparam int ROW_W_DEF    = 9;
  localparam int ITER_W_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    DRAIN,
    SWAP,
    DONE
  } heat_seq_state_t;

endpackage

// File: rtl/heat_solver_sequencer_if.sv
// Row-step handshake between the sequencer (master) and the column solvers (slave).
import heat_seq_pkg::*;

interface heat_solver_sequencer_if #(
  parameter int ROW_W = ROW_W_DEF
);
  logic             step_valid;
  logic [ROW_W-1:0] step_row;
  logic             step_ready;
  logic             solver_idle;

  modport master (output step_valid, output step_row, input step_ready, input solver_idle);
  modport slave  (input step_valid, input step_row, output step_ready, output solver_idle);
endinterface

// File: rtl/heat_seq_row_counter.sv
// Row index register for the current iteration; flags the last grid row.
import heat_seq_pkg::*;

module heat_seq_row_counter #(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int ROW_W    = ROW_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  // Row register: clear has priority over increment.
  always_ff @(posedge clk) begin
    if (reset || clr) row <= '0;
    else if (inc)     row <= row + 1'b1;
  end

  assign last = (row == ROW_W'(NUM_ROWS - 1));

endmodule

// File: rtl/heat_solver_sequencer.sv
// Sequences N diffusion iterations of the heat-map solver array.
// Optional build macro HEAT_SEQ_CYCLE_COUNT_EN adds the run_cycles readout.
//
// state | meaning
// IDLE  | after reset, waiting for a start edge
// STEP  | issuing row-step requests 0..NUM_ROWS-1
// DRAIN | waiting for the solver pipeline to empty
// SWAP  | one cycle: flip ping-pong buffer, count the iteration
// DONE  | run finished, done_out high until the next start edge
import heat_seq_pkg::*;

module heat_solver_sequencer #(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int ROW_W    = ROW_W_DEF,
  parameter int ITER_W   = ITER_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_in,
  input  logic [ITER_W-1:0]     iter_n_in,
  heat_solver_sequencer_if.master bus,
  output logic                  buf_sel,
  output logic [ITER_W-1:0]     iter_cur,
  output logic                  busy_out,
  output logic                  done_out
`ifdef HEAT_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]           run_cycles
`endif
);

  heat_seq_state_t  state, state_nxt;
  logic             start_q;
  logic             start_rise;
  logic             start_accept;
  logic             row_clr, row_inc, row_last;
  logic [ROW_W-1:0] row;
  logic [ITER_W-1:0] n_q;

  assign start_rise = start_in & ~start_q;

  // Start edge history keeps sampling through reset so a level held across reset never launches.
  always_ff @(posedge clk) begin
    start_q <= start_in;
  end

  heat_seq_row_counter #(
    .NUM_ROWS (NUM_ROWS),
    .ROW_W    (ROW_W)
  ) u_row (
    .clk   (clk),
    .reset (reset),
    .clr   (row_clr),
    .inc   (row_inc),
    .row   (row),
    .last  (row_last)
  );

  assign bus.step_row = row;

  // Next-state and row-counter control.
  always_comb begin
    state_nxt    = state;
    start_accept = 1'b0;
    row_clr      = 1'b0;
    row_inc      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start_rise) begin
          start_accept = 1'b1;
          row_clr      = 1'b1;
          state_nxt    = (iter_n_in == '0) ? DONE : STEP;
        end
      end
      STEP: begin
        if (bus.step_valid && bus.step_ready) begin
          if (row_last) begin
            row_clr   = 1'b1;
            state_nxt = DRAIN;
          end else begin
            row_inc   = 1'b1;
          end
        end
      end
      DRAIN: if (bus.solver_idle) state_nxt = SWAP;
      SWAP:  state_nxt = ((iter_cur + ITER_W'(1)) == n_q) ? DONE : STEP;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus.step_valid <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      buf_sel        <= 1'b0;
      iter_cur       <= '0;
      n_q            <= '0;
    end else begin
      state          <= state_nxt;
      bus.step_valid <= (state_nxt == STEP);
      busy_out       <= (state_nxt == STEP) || (state_nxt == DRAIN) || (state_nxt == SWAP);
      done_out       <= (state_nxt == DONE);
      if (start_accept) begin
        n_q      <= iter_n_in;
        iter_cur <= '0;
      end else if (state == SWAP) begin
        iter_cur <= iter_cur + ITER_W'(1);
        buf_sel  <= ~buf_sel;
      end
    end
  end

`ifdef HEAT_SEQ_CYCLE_COUNT_EN
  // Run length counter; the launch cycle itself is counted so the value equals start-to-done latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cycles <= '0;
    end else if (start_accept) begin
      run_cycles <= (iter_n_in == '0) ? 32'd0 : 32'd1;
    end else if (busy_out && (run_cycles != 32'hFFFF_FFFF)) begin
      run_cycles <= run_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_heat_solver_sequencer.sv
// Directed bench for heat_solver_sequencer with a 4-row grid.
module tb_heat_solver_sequencer;

  localparam int NUM_ROWS = 4;
  localparam int ROW_W    = 2;
  localparam int ITER_W   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start_in = 1'b0;
  logic [ITER_W-1:0] iter_n_in = '0;
  logic              buf_sel;
  logic [ITER_W-1:0] iter_cur;
  logic              busy_out;
  logic              done_out;
`ifdef HEAT_SEQ_CYCLE_COUNT_EN
  logic [31:0]       run_cycles;
`endif

  int checks = 0;
  int errors = 0;

  heat_solver_sequencer_if #(.ROW_W(ROW_W)) bus ();

  heat_solver_sequencer #(
    .NUM_ROWS (NUM_ROWS),
    .ROW_W    (ROW_W),
    .ITER_W   (ITER_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_in  (start_in),
    .iter_n_in (iter_n_in),
    .bus       (bus),
    .buf_sel   (buf_sel),
    .iter_cur  (iter_cur),
    .busy_out  (busy_out),
    .done_out  (done_out)
`ifdef HEAT_SEQ_CYCLE_COUNT_EN
    ,
    .run_cycles (run_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start_in = 1'b0;
    bus.step_ready = 1'b1;
    bus.solver_idle = 1'b1;
    repeat (3) tick();
    checks++; if (bus.step_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.step_valid); end
    checks++; if (bus.step_row !== 2'd0) begin errors++; $display("FAIL reset_row got %0d want 0", bus.step_row); end
    checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL reset_buf got %0b want 0", buf_sel); end
    checks++; if (iter_cur !== 16'd0) begin errors++; $display("FAIL reset_iter got %0d want 0", iter_cur); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_out); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done_out); end
    reset = 1'b0;
    repeat (2) tick();
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", busy_out); end
  endtask

  task automatic test_nominal;
    bit ev [13] = '{1,1,1,1,0,0,1,1,1,1,0,0,0};
    int er [13] = '{0,1,2,3,0,0,0,1,2,3,0,0,0};
    start_in = 1'b1;
    iter_n_in = 16'd2;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 1) start_in = 1'b0;
      checks++; if (bus.step_valid !== ev[k-1]) begin errors++; $display("FAIL nom_valid k=%0d got %0b want %0b", k, bus.step_valid, ev[k-1]); end
      if (ev[k-1]) begin
        checks++; if (bus.step_row !== ROW_W'(er[k-1])) begin errors++; $display("FAIL nom_row k=%0d got %0d want %0d", k, bus.step_row, er[k-1]); end
      end
      checks++; if (done_out !== (k == 13)) begin errors++; $display("FAIL nom_done k=%0d got %0b want %0b", k, done_out, (k == 13)); end
      if (k == 7) begin
        checks++; if (buf_sel !== 1'b1) begin errors++; $display("FAIL nom_buf1 got %0b want 1", buf_sel); end
        checks++; if (iter_cur !== 16'd1) begin errors++; $display("FAIL nom_iter1 got %0d want 1", iter_cur); end
      end
    end
    checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL nom_buf_end got %0b want 0", buf_sel); end
    checks++; if (iter_cur !== 16'd2) begin errors++; $display("FAIL nom_iter_end got %0d want 2", iter_cur); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL nom_busy_end got %0b want 0", busy_out); end
`ifdef HEAT_SEQ_CYCLE_COUNT_EN
    checks++; if (run_cycles !== 32'd13) begin errors++; $display("FAIL nom_run_cycles got %0d want 13", run_cycles); end
`endif
  endtask

  task automatic test_backpressure;
    int done_k = 0;
    start_in = 1'b1;
    iter_n_in = 16'd1;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      tick();
      if (k == 1) start_in = 1'b0;
      if (k >= 3 && k <= 6) begin
        checks++; if (bus.step_valid !== 1'b1) begin errors++; $display("FAIL bp_valid k=%0d got %0b want 1", k, bus.step_valid); end
        checks++; if (bus.step_row !== 2'd2) begin errors++; $display("FAIL bp_row k=%0d got %0d want 2", k, bus.step_row); end
      end
      if (k == 3) bus.step_ready = 1'b0;
      if (k == 6) bus.step_ready = 1'b1;
      if (done_out) done_k = k;
    end
    checks++; if (done_k !== 10) begin errors++; $display("FAIL bp_latency got %0d want 10", done_k); end
    checks++; if (buf_sel !== 1'b1) begin errors++; $display("FAIL bp_buf got %0b want 1", buf_sel); end
    checks++; if (iter_cur !== 16'd1) begin errors++; $display("FAIL bp_iter got %0d want 1", iter_cur); end
  endtask

  task automatic test_zero_iter;
    start_in = 1'b1;
    iter_n_in = 16'd0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) start_in = 1'b0;
      checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL zero_done k=%0d got %0b want 1", k, done_out); end
      checks++; if (bus.step_valid !== 1'b0) begin errors++; $display("FAIL zero_valid k=%0d got %0b want 0", k, bus.step_valid); end
      checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL zero_busy k=%0d got %0b want 0", k, busy_out); end
    end
    checks++; if (buf_sel !== 1'b1) begin errors++; $display("FAIL zero_buf got %0b want 1", buf_sel); end
  endtask

  task automatic test_drain_stall;
    int done_k = 0;
    start_in = 1'b1;
    iter_n_in = 16'd1;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      tick();
      if (k == 1) start_in = 1'b0;
      if (k >= 5 && k <= 10) begin
        checks++; if ({busy_out, bus.step_valid, buf_sel} !== 3'b101) begin errors++; $display("FAIL drain_hold k=%0d got busy/valid/buf %b want 101", k, {busy_out, bus.step_valid, buf_sel}); end
      end
      if (k == 5) bus.solver_idle = 1'b0;
      if (k == 10) bus.solver_idle = 1'b1;
      if (done_out) done_k = k;
    end
    checks++; if (done_k !== 12) begin errors++; $display("FAIL drain_latency got %0d want 12", done_k); end
    checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL drain_buf got %0b want 0", buf_sel); end
    checks++; if (iter_cur !== 16'd1) begin errors++; $display("FAIL drain_iter got %0d want 1", iter_cur); end
  endtask

  task automatic test_start_ignored;
    int done_k = 0;
    start_in = 1'b1;
    iter_n_in = 16'd2;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      tick();
      if (k == 1) start_in = 1'b0;
      if (k == 3) start_in = 1'b1;
      if (k == 4) begin
        checks++; if (bus.step_row !== 2'd3) begin errors++; $display("FAIL ign_row got %0d want 3", bus.step_row); end
      end
      if (k == 5) begin
        start_in = 1'b0;
        checks++; if (bus.step_valid !== 1'b0) begin errors++; $display("FAIL ign_drain_valid got %0b want 0", bus.step_valid); end
      end
      if (done_out) done_k = k;
    end
    checks++; if (done_k !== 13) begin errors++; $display("FAIL ign_latency got %0d want 13", done_k); end
    checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL ign_buf got %0b want 0", buf_sel); end
    done_k = 0;
    start_in = 1'b1;
    iter_n_in = 16'd1;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      tick();
      if (k == 1) begin
        start_in = 1'b0;
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL rerun_done_drop got %0b want 0", done_out); end
        checks++; if (iter_cur !== 16'd0) begin errors++; $display("FAIL rerun_iter_clr got %0d want 0", iter_cur); end
      end
      if (done_out) done_k = k;
    end
    checks++; if (done_k !== 7) begin errors++; $display("FAIL rerun_latency got %0d want 7", done_k); end
    checks++; if (buf_sel !== 1'b1) begin errors++; $display("FAIL rerun_buf got %0b want 1", buf_sel); end
  endtask

  task automatic test_reset_mid;
    start_in = 1'b1;
    iter_n_in = 16'd3;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 7) begin
        checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL mid_buf_swap got %0b want 0", buf_sel); end
      end
    end
    checks++; if ({busy_out, bus.step_valid} !== 2'b10) begin errors++; $display("FAIL mid_in_drain got busy/valid %b want 10", {busy_out, bus.step_valid}); end
    checks++; if (iter_cur !== 16'd1) begin errors++; $display("FAIL mid_iter got %0d want 1", iter_cur); end
    reset = 1'b1;
    tick();
    checks++; if ({bus.step_valid, buf_sel, busy_out, done_out} !== 4'b0000) begin errors++; $display("FAIL mid_reset_flags got %b want 0000", {bus.step_valid, buf_sel, busy_out, done_out}); end
    checks++; if (iter_cur !== 16'd0) begin errors++; $display("FAIL mid_reset_iter got %0d want 0", iter_cur); end
    checks++; if (bus.step_row !== 2'd0) begin errors++; $display("FAIL mid_reset_row got %0d want 0", bus.step_row); end
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if ({bus.step_valid, busy_out, done_out} !== 3'b000) begin errors++; $display("FAIL no_relaunch k=%0d got %b want 000", k, {bus.step_valid, busy_out, done_out}); end
    end
    start_in = 1'b0;
    tick();
  endtask

  initial begin
    bus.step_ready = 1'b1;
    bus.solver_idle = 1'b1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_zero_iter();
    test_drain_stall();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
